keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Upstream stage of Keypad_Decoder for the 4x4 calculator keypad.
//  - Walks a one-hot drive across the keypad columns and samples the rows through a 2-FF synchronizer.
//  - Debounces whole scan frames; only a clean single key is accepted.
//  - Presents a stable one-hot (key_rows, key_cols) pair to Keypad_Decoder, plus a one-cycle key_valid strobe per accepted press.
// PARAMETERS
//  SCAN_DIV         50000  clk cycles each column is driven (dwell); legal range >= 4
//  DEBOUNCE_FRAMES  4      consecutive agreeing frames needed to accept a press or a release; >= 1
// PORTS
//  clk        in   1  system clock
//  reset      in   1  synchronous, active-high reset
//  rows_in    in   4  raw keypad row pins, asynchronous, active-high; bit0 = top row
//  col_drive  out  4  one-hot column drive to keypad; bit0 = left column
//  key_rows   out  4  one-hot row of the last accepted key, to Keypad_Decoder.rows
//  key_cols   out  4  one-hot column of the last accepted key, to Keypad_Decoder.columns
//  key_valid  out  1  1-cycle pulse: a new debounced key has been accepted
//  key_held   out  1  level: the accepted key is still debounced-pressed
// BEHAVIOUR
//  Reset values (cycle after reset is sampled high):
//  - col_drive = 4'b0001, column index = 0, dwell count = 0
//  - synchronizer FFs = 0, snapshot = 0, state = IDLE, frame count = 0
//  - key_rows = key_cols = 4'b0000, key_valid = 0, key_held = 0
//  - Reset mid-operation aborts any debounce in progress; no key_valid is produced.
//  Scan:
//  - Dwell count runs 0..SCAN_DIV-1 per column.
//  - On count SCAN_DIV-1, the synchronized rows are stored in snapshot[4*col+3 : 4*col].
//  - The next cycle, col_drive rotates left (4'b1000 wraps to 4'b0001).
//  - frame_done pulses 1 cycle, the cycle after the column-3 sample is stored.
//  - One frame = 4*SCAN_DIV cycles. Column timing is free-running and never stalls.
//  Frame classification, evaluated on frame_done:
//  - NONE: snapshot has zero bits set.
//  - ONE: exactly one bit set.
//  - MULTI: two or more bits set.
//  - "has K": snapshot bit of candidate/held key K is set.
//  FSM, transitions taken only on frame_done; cnt = frame counter:
//  - IDLE: ONE -> DEB_PRESS, cand = that key, cnt = 1. NONE or MULTI -> stay.
//  - DEB_PRESS, frame ONE and equal to cand: cnt+1.
//    - If cnt+1 == DEBOUNCE_FRAMES -> PRESSED; latch key_rows/key_cols from cand; key_held = 1; key_valid = 1 for exactly one cycle.
//    - Any other frame -> IDLE, cnt = 0.
//  - DEB_PRESS with DEBOUNCE_FRAMES = 1: acceptance happens on the IDLE->DEB_PRESS frame itself, so IDLE goes directly to PRESSED.
//  - PRESSED: frame has K -> stay, even if other keys are also set; no repeat key_valid. Frame lacks K -> DEB_RELEASE, cnt = 1.
//  - DEB_RELEASE, frame lacks K: cnt+1; if it reaches DEBOUNCE_FRAMES -> IDLE with key_held = 0. Frame has K -> PRESSED; key_held stays 1, no key_valid.
//  Output rules:
//  - key_rows/key_cols change only together with key_valid and hold their value through release until the next accepted key.
//  - Keypad_Decoder's registered output is valid 1 cycle after key_valid.
//  - key_valid and key_held are registered; no combinational path from rows_in to any output.
//  - cnt width = $clog2(DEBOUNCE_FRAMES+1); it cannot overflow because it saturates at the transition.
// TESTING  (bench params SCAN_DIV=4, DEBOUNCE_FRAMES=3; frame = 16 clk)
//  1. Reset, rows_in=0 -> all outputs at reset values; col_drive steps 0001,0010,0100,1000,0001 every 4 clk; key_valid never set.
//  2. Key '5' modelled (rows_in=0010 only while col_drive=0010), held 10 frames
//     -> exactly one key_valid, 1 cycle after the 3rd frame_done; key_rows=0010, key_cols=0010, key_held=1; decoder gives 4'h5.
//  3. Bounce: '8' (rows 0100, col 0010) present 2 frames / absent 1 frame, repeated 5 times -> no key_valid, key_held=0.
//  4. Keys '1' and '9' pressed together from IDLE for 6 frames -> no key_valid; add '2' while '5' held -> no second key_valid.
//  5. '#' (rows 1000, cols 0100) accepted, then removed 2 frames and restored -> key_held stays 1, no key_valid.
//     Then removed 3 frames -> key_held=0 at 3rd frame_done+1; key_rows/key_cols stay 1000/0100.
//  6. reset pulsed 1 cycle during DEB_PRESS of '0' -> outputs at reset values next cycle; no key_valid.
//     A re-held '0' is accepted 3 full frames after reset is released.

Source files
------------

// File: rtl/keypad_scanner.sv
// Column scanner and frame debouncer for a 4x4 keypad. It drives the columns one-hot, samples
// the rows through a 2-FF synchronizer and accepts a single clean key as a one-hot row/column pair.
module keypad_scanner #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows_in,
  output logic [3:0] col_drive,
  output logic [3:0] key_rows,
  output logic [3:0] key_cols,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE   = CNT_W'(DEBOUNCE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_RELEASE} state_e;

  logic [DIV_W-1:0] dwell_q, dwell_d;
  logic [1:0]       col_q, col_d;
  logic [3:0]       col_drive_q, col_drive_d;
  logic [3:0]       sync1_q, sync2_q;
  logic [15:0]      snap_q, snap_d;
  logic             frame_done_q, frame_done_d;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       key_rows_q, key_rows_d;
  logic [3:0]       key_cols_q, key_cols_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;

  logic [4:0]       ones;
  logic [3:0]       only_idx;
  logic             frame_one;
  logic             has_k;
  logic             accept;
  logic [3:0]       acc_idx;

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    dwell_d      = dwell_q + 1'b1;
    col_d        = col_q;
    col_drive_d  = col_drive_q;
    snap_d       = snap_q;
    frame_done_d = 1'b0;
    if (dwell_q == DWELL_LAST) begin
      dwell_d              = '0;
      col_d                = col_q + 2'd1;
      col_drive_d          = {col_drive_q[2:0], col_drive_q[3]};
      snap_d[4*col_q +: 4] = sync2_q;
      frame_done_d         = (col_q == 2'd3);
    end
  end

  // Snapshot bit index is 4*col + row, so only_idx[1:0] is the row and only_idx[3:2] the column.
  always_comb begin
    ones     = '0;
    only_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (snap_q[i]) begin
        ones     = ones + 5'd1;
        only_idx = 4'(i);
      end
    end
    frame_one = (ones == 5'd1);
    has_k     = snap_q[cand_q];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_rows_d  = key_rows_q;
    key_cols_d  = key_cols_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    cnt_inc     = cnt_q + CNT_ONE;
    accept      = 1'b0;
    acc_idx     = cand_q;

    if (frame_done_q) begin
      unique case (state_q)
        IDLE: begin
          if (frame_one) begin
            if (CNT_ONE == CNT_DONE) begin
              accept  = 1'b1;
              acc_idx = only_idx;
            end else begin
              state_d = DEB_PRESS;
              cand_d  = only_idx;
              cnt_d   = CNT_ONE;
            end
          end
        end
        DEB_PRESS: begin
          if (frame_one && only_idx == cand_q) begin
            if (cnt_inc == CNT_DONE) accept = 1'b1;
            else                     cnt_d  = cnt_inc;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        PRESSED: begin
          if (!has_k) begin
            if (CNT_ONE == CNT_DONE) begin
              state_d    = IDLE;
              key_held_d = 1'b0;
            end else begin
              state_d = DEB_RELEASE;
              cnt_d   = CNT_ONE;
            end
          end
        end
        DEB_RELEASE: begin
          if (has_k) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_inc == CNT_DONE) begin
            state_d    = IDLE;
            cnt_d      = '0;
            key_held_d = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (accept) begin
      state_d     = PRESSED;
      cnt_d       = '0;
      cand_d      = acc_idx;
      key_rows_d  = 4'b0001 << acc_idx[1:0];
      key_cols_d  = 4'b0001 << acc_idx[3:2];
      key_valid_d = 1'b1;
      key_held_d  = 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      dwell_q      <= '0;
      col_q        <= '0;
      col_drive_q  <= 4'b0001;
      sync1_q      <= '0;
      sync2_q      <= '0;
      // NOTE: the snapshot store is cleared on reset so the first frame never classifies stale rows.
      snap_q       <= '0;
      frame_done_q <= 1'b0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      cand_q       <= '0;
      key_rows_q   <= '0;
      key_cols_q   <= '0;
      key_valid_q  <= 1'b0;
      key_held_q   <= 1'b0;
    end else begin
      dwell_q      <= dwell_d;
      col_q        <= col_d;
      col_drive_q  <= col_drive_d;
      sync1_q      <= rows_in;
      sync2_q      <= sync1_q;
      snap_q       <= snap_d;
      frame_done_q <= frame_done_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cand_q       <= cand_d;
      key_rows_q   <= key_rows_d;
      key_cols_q   <= key_cols_d;
      key_valid_q  <= key_valid_d;
      key_held_q   <= key_held_d;
    end
  end

  assign col_drive = col_drive_q;
  assign key_rows  = key_rows_q;
  assign key_cols  = key_cols_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model answers the column drive, and a frame-level
// reference model predicts key_valid / key_held / key_rows / key_cols every cycle.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rows_in;
  logic [3:0] col_drive, key_rows, key_cols;
  logic       key_valid, key_held;

  logic [15:0] pressed = '0;   // bit 4*col+row set = that key is physically down

  int n_tests = 0;
  int n_fail  = 0;

  // Frame-level reference model
  bit          m_held;
  int          m_key;
  int          m_cand;
  int          m_run;
  bit          m_pulse;
  int          m_accepts;
  logic [15:0] prev_mask;
  bit          have_prev;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_FRAMES(DEB)) dut (
    .clk       (clk),
    .reset     (reset),
    .rows_in   (rows_in),
    .col_drive (col_drive),
    .key_rows  (key_rows),
    .key_cols  (key_cols),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    rows_in = '0;
    for (int c = 0; c < 4; c++)
      if (col_drive[c]) rows_in = rows_in | pressed[4*c +: 4];
  end

  function automatic int kidx(input int row, input int col);
    return 4 * col + row;
  endfunction

  // Calculator keypad legend: digits as themselves, A-D as A-D, '*' = E, '#' = F.
  function automatic logic [3:0] decode(input logic [3:0] r, input logic [3:0] c);
    int ri = 0;
    int ci = 0;
    for (int i = 0; i < 4; i++) begin
      if (r[i]) ri = i;
      if (c[i]) ci = i;
    end
    case (ri * 4 + ci)
      0: return 4'h1;   1: return 4'h2;   2: return 4'h3;   3: return 4'hA;
      4: return 4'h4;   5: return 4'h5;   6: return 4'h6;   7: return 4'hB;
      8: return 4'h7;   9: return 4'h8;  10: return 4'h9;  11: return 4'hC;
      12: return 4'hE; 13: return 4'h0;  14: return 4'hF;  default: return 4'hD;
    endcase
  endfunction

  function automatic logic [3:0] exp_rows();
    return (m_key < 0) ? 4'b0000 : 4'(1 << (m_key % 4));
  endfunction

  function automatic logic [3:0] exp_cols();
    return (m_key < 0) ? 4'b0000 : 4'(1 << (m_key / 4));
  endfunction

  task automatic model_reset();
    m_held    = 1'b0;
    m_key     = -1;
    m_cand    = -1;
    m_run     = 0;
    m_pulse   = 1'b0;
    have_prev = 1'b0;
  endtask

  // One frame of keypad contents: count agreeing frames toward press or release.
  task automatic model_frame(input logic [15:0] mask);
    int n = $countones(mask);
    int k = -1;
    for (int i = 0; i < 16; i++) if (mask[i]) k = i;
    m_pulse = 1'b0;
    if (!m_held) begin
      if (n == 1 && m_run > 0 && k == m_cand) m_run++;
      else if (n == 1 && m_run == 0) begin
        m_cand = k;
        m_run  = 1;
      end else m_run = 0;
      if (m_run == DEB) begin
        m_held  = 1'b1;
        m_key   = m_cand;
        m_run   = 0;
        m_pulse = 1'b1;
        m_accepts++;
      end
    end else begin
      if (mask[m_key]) m_run = 0;
      else begin
        m_run++;
        if (m_run == DEB) begin
          m_held = 1'b0;
          m_run  = 0;
        end
      end
    end
  endtask

  // Called at the negedge of cycle 0 of a frame; returns at cycle 0 of the next frame.
  task automatic run_frame(input logic [15:0] mask, input int ncyc, output int valids);
    logic exp_v;
    logic [3:0] exp_col;
    valids  = 0;
    pressed = mask;
    for (int c = 0; c < ncyc; c++) begin
      if (c == 0) m_pulse = 1'b0;
      if (c == 1 && have_prev) model_frame(prev_mask);
      exp_v   = (c == 1) && m_pulse;
      exp_col = 4'(1 << (c / SCAN_DIV));
      n_tests += 5;
      if (col_drive !== exp_col) begin
        n_fail++;
        $display("FAIL col_drive cyc%0d: got %b want %b", c, col_drive, exp_col);
      end
      if (key_valid !== exp_v) begin
        n_fail++;
        $display("FAIL key_valid cyc%0d: got %b want %b", c, key_valid, exp_v);
      end
      if (key_held !== m_held) begin
        n_fail++;
        $display("FAIL key_held cyc%0d: got %b want %b", c, key_held, m_held);
      end
      if (key_rows !== exp_rows()) begin
        n_fail++;
        $display("FAIL key_rows cyc%0d: got %b want %b", c, key_rows, exp_rows());
      end
      if (key_cols !== exp_cols()) begin
        n_fail++;
        $display("FAIL key_cols cyc%0d: got %b want %b", c, key_cols, exp_cols());
      end
      if (key_valid === 1'b1) valids++;
      @(negedge clk);
    end
    if (ncyc == FRAME) begin
      prev_mask = mask;
      have_prev = 1'b1;
    end
  endtask

  task automatic run_frames(input logic [15:0] mask, input int n, output int valids);
    int v;
    valids = 0;
    for (int f = 0; f < n; f++) begin
      run_frame(mask, FRAME, v);
      valids += v;
    end
  endtask

  // Called at a negedge; leaves reset high for exactly one rising edge.
  task automatic do_reset();
    reset   = 1'b1;
    pressed = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_values(input string tag);
    n_tests++;
    if ({col_drive, key_rows, key_cols, key_valid, key_held} !== {4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL %s reset values: got col=%b rows=%b cols=%b v=%b h=%b want 0001/0000/0000/0/0",
               tag, col_drive, key_rows, key_cols, key_valid, key_held);
    end
  endtask

  task automatic test_reset();
    int v;
    do_reset();
    check_reset_values("test_reset");
    run_frames(16'h0000, 2, v);
    n_tests++;
    if (v !== 0) begin n_fail++; $display("FAIL reset_idle_valids: got %0d want 0", v); end
  endtask

  task automatic test_single_key();
    int v;
    int total = 0;
    for (int f = 0; f < 10; f++) begin
      run_frame(16'(1 << kidx(1, 1)), FRAME, v);
      total += v;
      n_tests++;
      if (v !== ((f == 3) ? 1 : 0)) begin
        n_fail++;
        $display("FAIL key5_valid_frame%0d: got %0d want %0d", f, v, (f == 3) ? 1 : 0);
      end
    end
    n_tests += 3;
    if (total !== 1) begin n_fail++; $display("FAIL key5_total_valids: got %0d want 1", total); end
    if ({key_rows, key_cols, key_held} !== {4'b0010, 4'b0010, 1'b1}) begin
      n_fail++;
      $display("FAIL key5_outputs: got %b/%b/%b want 0010/0010/1", key_rows, key_cols, key_held);
    end
    if (decode(key_rows, key_cols) !== 4'h5) begin
      n_fail++;
      $display("FAIL key5_decode: got %h want 5", decode(key_rows, key_cols));
    end
    run_frames(16'h0000, 5, v);
    n_tests++;
    if ({key_held, key_rows, key_cols} !== {1'b0, 4'b0010, 4'b0010}) begin
      n_fail++;
      $display("FAIL key5_release: got h=%b %b/%b want 0 0010/0010", key_held, key_rows, key_cols);
    end
  endtask

  task automatic test_bounce();
    int v;
    int total = 0;
    for (int r = 0; r < 5; r++) begin
      run_frames(16'(1 << kidx(2, 1)), 2, v);
      total += v;
      run_frames(16'h0000, 1, v);
      total += v;
    end
    n_tests += 2;
    if (total !== 0) begin n_fail++; $display("FAIL bounce_valids: got %0d want 0", total); end
    if (key_held !== 1'b0) begin n_fail++; $display("FAIL bounce_held: got %b want 0", key_held); end
  endtask

  task automatic test_multi_key();
    int v;
    run_frames(16'(1 << kidx(0, 0)) | 16'(1 << kidx(2, 2)), 6, v);
    n_tests++;
    if (v !== 0) begin n_fail++; $display("FAIL multi_idle_valids: got %0d want 0", v); end
    run_frames(16'h0000, 1, v);
    run_frames(16'(1 << kidx(1, 1)), 4, v);
    n_tests++;
    if (v !== 1) begin n_fail++; $display("FAIL multi_key5_valids: got %0d want 1", v); end
    run_frames(16'(1 << kidx(1, 1)) | 16'(1 << kidx(0, 1)), 3, v);
    n_tests += 2;
    if (v !== 0) begin n_fail++; $display("FAIL multi_add2_valids: got %0d want 0", v); end
    if (key_held !== 1'b1 || decode(key_rows, key_cols) !== 4'h5) begin
      n_fail++;
      $display("FAIL multi_add2_key: got h=%b key=%h want 1 5", key_held, decode(key_rows, key_cols));
    end
    run_frames(16'h0000, 4, v);
  endtask

  task automatic test_hold_release();
    int v;
    int total;
    logic [15:0] hash = 16'(1 << kidx(3, 2));
    run_frames(hash, 4, v);
    n_tests++;
    if (v !== 1) begin n_fail++; $display("FAIL hash_accept_valids: got %0d want 1", v); end
    run_frames(16'h0000, 2, total);
    run_frames(hash, 2, v);
    total += v;
    n_tests += 2;
    if (total !== 0) begin n_fail++; $display("FAIL hash_glitch_valids: got %0d want 0", total); end
    if (key_held !== 1'b1) begin n_fail++; $display("FAIL hash_glitch_held: got %b want 1", key_held); end
    run_frames(16'h0000, 3, v);
    n_tests++;
    if (key_held !== 1'b1) begin n_fail++; $display("FAIL hash_held_at_3rd_done: got %b want 1", key_held); end
    run_frames(16'h0000, 1, v);
    n_tests++;
    if ({key_held, key_rows, key_cols} !== {1'b0, 4'b1000, 4'b0100}) begin
      n_fail++;
      $display("FAIL hash_released: got h=%b %b/%b want 0 1000/0100", key_held, key_rows, key_cols);
    end
  endtask

  task automatic test_reset_mid_debounce();
    int v;
    int total = 0;
    logic [15:0] zero_key = 16'(1 << kidx(3, 1));
    run_frames(zero_key, 2, v);
    run_frame(zero_key, 5, v);
    do_reset();
    check_reset_values("reset_mid");
    for (int f = 0; f < 5; f++) begin
      run_frame(zero_key, FRAME, v);
      total += v;
      n_tests++;
      if (v !== ((f == 3) ? 1 : 0)) begin
        n_fail++;
        $display("FAIL key0_after_reset_frame%0d: got %0d want %0d", f, v, (f == 3) ? 1 : 0);
      end
    end
    n_tests += 2;
    if (total !== 1) begin n_fail++; $display("FAIL key0_total_valids: got %0d want 1", total); end
    if (decode(key_rows, key_cols) !== 4'h0) begin
      n_fail++;
      $display("FAIL key0_decode: got %h want 0", decode(key_rows, key_cols));
    end
    run_frames(16'h0000, 4, v);
  endtask

  task automatic test_random();
    int v;
    int total = 0;
    int start = m_accepts;
    logic [15:0] mask = '0;
    for (int f = 0; f < 50; f++) begin
      int r = int'($urandom_range(0, 9));
      if (r >= 4 && r < 7)  mask = 16'(1 << $urandom_range(0, 15));
      else if (r == 7)      mask = 16'(1 << $urandom_range(0, 15)) | 16'(1 << $urandom_range(0, 15));
      else if (r >= 8)      mask = '0;
      run_frame(mask, FRAME, v);
      total += v;
    end
    run_frame(16'h0000, FRAME, v);
    total += v;
    n_tests++;
    if (total !== m_accepts - start) begin
      n_fail++;
      $display("FAIL random_total_valids: got %0d want %0d", total, m_accepts - start);
    end
  endtask

  initial begin
    m_accepts = 0;
    model_reset();
    test_reset();
    test_single_key();
    test_bounce();
    test_multi_key();
    test_hold_release();
    test_reset_mid_debounce();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
